memory_bank: RTL
================

MEMORY_BANK -- requirements
Module: memory_bank

Interface
REQ-001 Parameter DATA_W, default 16, storage word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 4, number of storage entries; SHALL satisfy 2 <= DEPTH <= 2**ADDR_W.
REQ-003 Parameter ADDR_W, default 2, address width in bits.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-005 rstn  input  1  reset; synchronous and active-low, sampled on the rising edge of clk.
REQ-006 sel  input  1  access request, sampled each rising edge.
REQ-007 wr  input  1  direction when sel=1: 1 = write, 0 = read.
REQ-008 addr  input  ADDR_W  entry index for the access.
REQ-009 wdata  input  DATA_W  write data.
REQ-010 be  input  DATA_W/8  byte enables; be[i] controls wdata[8i+7:8i].
REQ-011 clr  input  1  request to zero all entries.
REQ-012 rdata  output  DATA_W  read data; valid only while rvalid=1.
REQ-013 rvalid  output  1  one-cycle read-data-valid pulse.
REQ-014 err  output  1  one-cycle protocol-error pulse.
REQ-015 busy  output  1  high while a clear sequence is running.

Function
REQ-016 The block SHALL contain a two-state FSM: IDLE and CLEAR.
REQ-017 In IDLE, an access is accepted when sel=1, clr=0 and addr<DEPTH.
REQ-018 Accepted write: at that edge, each byte with be[i]=1 SHALL take the wdata byte; bytes with be[i]=0 and all other entries SHALL be unchanged; rvalid stays 0.
REQ-019 Accepted read: on the next edge, rdata SHALL equal the addressed entry and rvalid SHALL be 1 for exactly one cycle (latency 1); back-to-back reads SHALL produce one rvalid per cycle.
REQ-020 A read accepted in the cycle after a write to the same address SHALL return the newly written data.
REQ-021 rdata SHALL be all-zero whenever rvalid=0.
REQ-022 sel=1 with addr>=DEPTH: storage unchanged; err=1 for one cycle on the next edge; rvalid=0.
REQ-023 clr=1 in IDLE: FSM goes to CLEAR at that edge; the clear counter loads 0; any sel request in the same cycle is dropped without err.
REQ-024 In CLEAR: each cycle, entry[counter] SHALL be written to zero and the counter incremented; after entry DEPTH-1 is zeroed, the FSM SHALL return to IDLE and the counter wraps to 0.
REQ-025 busy SHALL be high for exactly DEPTH consecutive cycles, starting the cycle after clr is sampled.
REQ-026 sel=1 while busy=1: access ignored, storage unaffected by the request; err=1 for one cycle on the next edge.
REQ-027 clr=1 while busy=1 SHALL be ignored; the sequence neither restarts nor extends.
REQ-028 err and rvalid SHALL never both be 1 in the same cycle.

Reset
REQ-029 When rstn=0 at a rising edge, all entries SHALL become 0, FSM SHALL enter IDLE, and the counter, rdata, rvalid, err and busy SHALL be 0 from that edge.
REQ-030 Reset SHALL take priority over every other input, including mid-CLEAR; the clear sequence is aborted and SHALL NOT resume after reset release.
REQ-031 With rstn=0, sel, wr and clr SHALL have no effect.

Verification
REQ-032 Defaults: write addr=2, wdata=16'hA5C3, be=2'b11; read addr=2 next cycle -> following cycle rdata=16'hA5C3, rvalid=1 for one cycle, err=0.
REQ-033 Byte enable: entry 1 = 16'h1234; write addr=1, wdata=16'hFFFF, be=2'b01; read addr 1 -> rdata=16'h12FF.
REQ-034 DEPTH=3, ADDR_W=2: read addr=3 -> err=1 one cycle, rvalid=0; write addr=3 -> err=1 one cycle, entries 0..2 unchanged.
REQ-035 All four entries nonzero; pulse clr -> busy=1 for exactly 4 cycles; read during busy -> err=1 one cycle, rvalid=0; after busy falls, reads of addr 0..3 all return 0.
REQ-036 Assert rstn=0 in the 2nd cycle of CLEAR -> next edge busy=0 and all outputs 0; after release, busy stays 0 and reads return 0.
REQ-037 Reads of addr 0,1,2,3 on 4 consecutive cycles -> rvalid high for 4 consecutive cycles, with rdata matching each entry in order.

Source files
------------

// File: rtl/memory_bank_if.sv
// Access bus for memory_bank.
// The requester drives the command side and the bank drives the response side.
interface memory_bank_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 2
);
    logic                  sel;
    logic                  wr;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   be;
    logic                  clr;
    logic [DATA_W-1:0]     rdata;
    logic                  rvalid;
    logic                  err;
    logic                  busy;

    modport master (
        output sel, wr, addr, wdata, be, clr,
        input  rdata, rvalid, err, busy
    );

    modport slave (
        input  sel, wr, addr, wdata, be, clr,
        output rdata, rvalid, err, busy
    );
endinterface

// File: rtl/memory_bank.sv
// Small register-file memory bank.
// Byte-enabled writes and 1-cycle-latency reads.
// Addresses at or beyond DEPTH raise a one-cycle error pulse.
// A clear request walks a counter over every entry, one entry per cycle, while busy is high.
module memory_bank #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic         clk,
    input  logic         rstn,
    memory_bank_if.slave bus
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // DEPTH may equal 2**ADDR_W, so the range compare needs one extra bit.
    localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic [IDX_W-1:0]  cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] rdata_p1;
    logic              vld_p1;
    logic              err_p1;
    logic              busy_p1;

    logic              in_range;
    logic [IDX_W-1:0]  idx;

    // Replace only the bytes whose enable bit is set.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [NB-1:0]     en
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < NB; i++) begin
            if (en[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign in_range = ({1'b0, bus.addr} < DEPTH_L);
    assign idx      = bus.addr[IDX_W-1:0];

    // Control FSM, storage update and registered response outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            rdata_p1 <= '0;
            vld_p1   <= 1'b0;
            err_p1   <= 1'b0;
            busy_p1  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // Response pulses default low; rdata is forced to zero when not valid.
            rdata_p1 <= '0;
            vld_p1   <= 1'b0;
            err_p1   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.clr) begin
                        // A request presented together with clr is dropped silently.
                        state   <= CLEAR;
                        cnt     <= '0;
                        busy_p1 <= 1'b1;
                    end else if (bus.sel) begin
                        if (!in_range) begin
                            err_p1 <= 1'b1;
                        end else if (bus.wr) begin
                            mem[idx] <= merge_bytes(mem[idx], bus.wdata, bus.be);
                        end else begin
                            rdata_p1 <= mem[idx];
                            vld_p1   <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    // Accesses are refused while clearing.
                    // A further clr is ignored, so the sequence length stays fixed.
                    mem[cnt] <= '0;
                    err_p1   <= bus.sel;
                    if (cnt == LAST_IDX) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        busy_p1 <= 1'b0;
                    end else begin
                        cnt <= cnt + IDX_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.rdata  = rdata_p1;
    assign bus.rvalid = vld_p1;
    assign bus.err    = err_p1;
    assign bus.busy   = busy_p1;
endmodule
